// File: rtl/mem_line_server.sv
// Critical-word-first line-fill server: fetches an 8-word line from a one-cycle-latency
// memory starting at the missed word, flags the critical word early and returns the whole line.
module mem_line_server #(
    parameter int LINE_WORDS = 8
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [31:0]                req_addr,
    output logic                       mem_en,
    output logic [31:0]                mem_addr,
    input  logic [31:0]                mem_rdata,
    output logic                       crit_valid,
    output logic [31:0]                crit_word,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [31:0]                resp_addr,
    output logic [32*LINE_WORDS-1:0]   resp_line
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LAST  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                    r_state;
    logic                      r_req_ready;
    logic                      r_mem_en;
    logic [31:0]               r_mem_addr;
    logic                      r_crit_valid;
    logic [31:0]               r_crit_word;
    logic                      r_resp_valid;
    logic [31:0]               r_resp_addr;
    logic [32*LINE_WORDS-1:0]  r_line;
    logic [26:0]               r_base;
    logic [2:0]                r_crit_idx;
    logic [2:0]                r_issue_cnt;
    logic                      r_cap_pend;
    logic [2:0]                r_cap_idx;
    logic                      r_cap_first;
    logic [2:0]                w_next_idx;
    logic                      w_unused_addr_lsbs;

    // Byte offset within a word never matters: fetches are word aligned.
    assign w_unused_addr_lsbs = ^req_addr[1:0];

    // Modulo-8 wrap is implicit in the 3-bit add.
    assign w_next_idx = r_crit_idx + r_issue_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_mem_en     <= 1'b0;
            r_mem_addr   <= '0;
            r_crit_valid <= 1'b0;
            r_crit_word  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_addr  <= '0;
            r_line       <= '0;
            r_base       <= '0;
            r_crit_idx   <= '0;
            r_issue_cnt  <= '0;
            r_cap_pend   <= 1'b0;
            r_cap_idx    <= '0;
            r_cap_first  <= 1'b0;
        end else begin
            r_crit_valid <= 1'b0;
            r_cap_pend   <= 1'b0;

            // Read data arrives one cycle after the strobe; the pending tag trails each issue.
            if (r_cap_pend) begin
                r_line[{r_cap_idx, 5'b0} +: 32] <= mem_rdata;
                if (r_cap_first) begin
                    r_crit_valid <= 1'b1;
                    r_crit_word  <= mem_rdata;
                end
            end

            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_state     <= FETCH;
                        r_req_ready <= 1'b0;
                        r_base      <= req_addr[31:5];
                        r_crit_idx  <= req_addr[4:2];
                        r_issue_cnt <= 3'd1;
                        r_mem_en    <= 1'b1;
                        r_mem_addr  <= {req_addr[31:2], 2'b00};
                    end
                end
                FETCH: begin
                    r_cap_pend  <= 1'b1;
                    r_cap_idx   <= r_mem_addr[4:2];
                    r_cap_first <= (r_mem_addr[4:2] == r_crit_idx);
                    // Counter wraps to zero once all eight words have been issued.
                    if (r_issue_cnt == 3'd0) begin
                        r_state    <= LAST;
                        r_mem_en   <= 1'b0;
                        r_mem_addr <= '0;
                    end else begin
                        r_mem_addr  <= {r_base, w_next_idx, 2'b00};
                        r_issue_cnt <= r_issue_cnt + 3'd1;
                    end
                end
                LAST: begin
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_addr  <= {r_base, 5'b0};
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_en     = r_mem_en;
    assign mem_addr   = r_mem_addr;
    assign crit_valid = r_crit_valid;
    assign crit_word  = r_crit_word;
    assign resp_valid = r_resp_valid;
    assign resp_addr  = r_resp_addr;
    assign resp_line  = r_line;

endmodule
